// File: rtl/squash_pkg.sv
// Shared types and defaults for the squash rally sequencer.
package squash_pkg;

  localparam int unsigned NUM_LEDS_DEF    = 16;
  localparam int unsigned TICK_START_DEF  = 6_250_000;
  localparam int unsigned TICK_STEP_DEF   = 500_000;
  localparam int unsigned TICK_MIN_DEF    = 1_000_000;
  localparam int unsigned HIT_WIN_DEF     = 2;
  localparam int unsigned MAX_SCORE_DEF   = 3;
  localparam int unsigned FLASH_TICKS_DEF = 4;
  localparam int unsigned PERIOD_W        = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_OUT,
    ST_IN,
    ST_MISS,
    ST_WIN
  } state_e;

endpackage

// File: rtl/squash_tick_gen.sv
// Ball step timer: one-cycle tick every `period` clocks, restartable via clear.
module squash_tick_gen
  import squash_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // >= guards against a period shrinking below the running count
  assign tick = (cnt_q >= period - PERIOD_W'(1));

  always_comb begin
    cnt_d = cnt_q + PERIOD_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/squash_rally_ctrl.sv
// Rally sequencer: ball travel, hit window, speed-up, score and miss/win display.
module squash_rally_ctrl
  import squash_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = NUM_LEDS_DEF,
  parameter int unsigned TICK_START  = TICK_START_DEF,
  parameter int unsigned TICK_STEP   = TICK_STEP_DEF,
  parameter int unsigned TICK_MIN    = TICK_MIN_DEF,
  parameter int unsigned HIT_WIN     = HIT_WIN_DEF,
  parameter int unsigned MAX_SCORE   = MAX_SCORE_DEF,
  parameter int unsigned FLASH_TICKS = FLASH_TICKS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rightplayer,
  output logic [NUM_LEDS-1:0] light,
  output logic [3:0]          ball_pos,
  output logic [1:0]          rightpscore,
  output logic                gamestate,
  output logic                hit_pulse,
  output logic                miss_pulse
);

  localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [3:0]          LAST_POS   = 4'(NUM_LEDS - 1);
  localparam logic [3:0]          WIN_POS    = 4'(HIT_WIN);
  localparam logic [1:0]          MAX_S      = 2'(MAX_SCORE);
  localparam logic [PERIOD_W-1:0] P_START    = PERIOD_W'(TICK_START);
  localparam logic [PERIOD_W-1:0] P_STEP     = PERIOD_W'(TICK_STEP);
  localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(TICK_MIN);
  localparam logic [FW-1:0]       FLASH_LAST = FW'(FLASH_TICKS - 1);
  localparam logic [NUM_LEDS-1:0] ONE        = NUM_LEDS'(1);

  state_e              state_q, state_d;
  logic [3:0]          pos_q, pos_d;
  logic [1:0]          score_q, score_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [FW-1:0]       flash_q, flash_d;
  logic [NUM_LEDS-1:0] light_q, light_d;
  logic                hit_q, hit_d, miss_q, miss_d;
  logic                btn_q, press, tick, clr;

  assign press = rightplayer & ~btn_q;

  squash_tick_gen u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (clr),
    .period (period_q),
    .tick   (tick)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    score_d  = score_q;
    period_d = period_q;
    flash_d  = flash_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    clr      = 1'b0;
    case (state_q)
      ST_IDLE: if (press) begin
        score_d  = '0;
        period_d = P_START;
        clr      = 1'b1;
        pos_d    = '0;
        state_d  = ST_SERVE;
      end
      ST_SERVE: if (tick) begin
        pos_d   = 4'd1;
        state_d = ST_OUT;
      end
      ST_OUT: if (tick) begin
        if (pos_q == LAST_POS) begin
          pos_d   = pos_q - 4'd1;
          state_d = ST_IN;
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end
      // an in-window press takes priority over a coincident tick
      ST_IN: if (press && (pos_q < WIN_POS)) begin
        score_d  = (score_q == MAX_S) ? MAX_S : score_q + 2'd1;
        hit_d    = 1'b1;
        clr      = 1'b1;
        period_d = (period_q >= P_MIN + P_STEP) ? period_q - P_STEP : P_MIN;
        if (score_d == MAX_S) begin
          state_d = ST_WIN;
        end else begin
          pos_d   = pos_q + 4'd1;
          state_d = ST_OUT;
        end
      end else if (tick) begin
        if (pos_q == '0) begin
          state_d = ST_MISS;
          miss_d  = 1'b1;
          flash_d = '0;
        end else begin
          pos_d = pos_q - 4'd1;
        end
      end
      ST_MISS: if (tick) begin
        if (flash_q == FLASH_LAST) state_d = ST_IDLE;
        else                       flash_d = flash_q + FW'(1);
      end
      ST_WIN: if (press) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // light follows next state so it changes on the same edge as ball_pos
    case (state_d)
      ST_SERVE, ST_OUT, ST_IN: light_d = ONE << pos_d;
      ST_MISS: begin
        if (state_q != ST_MISS) light_d = '1;
        else if (tick)          light_d = ~light_q;
        else                    light_d = light_q;
      end
      ST_WIN:  light_d = '1;
      default: light_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      score_q  <= '0;
      period_q <= P_START;
      flash_q  <= '0;
      light_q  <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      score_q  <= score_d;
      period_q <= period_d;
      flash_q  <= flash_d;
      light_q  <= light_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      btn_q    <= rightplayer;
    end
  end

  assign light       = light_q;
  assign ball_pos    = pos_q;
  assign rightpscore = score_q;
  assign gamestate   = (state_q == ST_SERVE) || (state_q == ST_OUT) || (state_q == ST_IN);
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_squash_rally_ctrl.sv
// Scoreboard bench for squash_rally_ctrl with short tick periods.
module tb_squash_rally_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rightplayer = 1'b0;
  logic [15:0] light;
  logic [3:0]  ball_pos;
  logic [1:0]  rightpscore;
  logic        gamestate, hit_pulse, miss_pulse;

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] last_l = '0;

  typedef struct {
    int          gap;
    bit          btn;
    logic [15:0] l;
    logic [3:0]  p;
    bit          pv;
    logic [1:0]  s;
    bit          g;
    bit          h;
    bit          m;
  } exp_t;

  exp_t sb[$];

  squash_rally_ctrl #(
    .NUM_LEDS(16), .TICK_START(8), .TICK_STEP(2), .TICK_MIN(4),
    .HIT_WIN(2), .MAX_SCORE(3), .FLASH_TICKS(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rightplayer (rightplayer),
    .light       (light),
    .ball_pos    (ball_pos),
    .rightpscore (rightpscore),
    .gamestate   (gamestate),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // gap = clocks after the previous event; btn = button level driven into that edge
  function automatic void push(int gap, bit btn, logic [15:0] l, int p, bit pv,
                               int s, bit g, bit h, bit m);
    exp_t e;
    e.gap = gap; e.btn = btn; e.l = l; e.p = 4'(p); e.pv = pv;
    e.s = 2'(s); e.g = g; e.h = h; e.m = m;
    sb.push_back(e);
  endfunction

  // ball travelling from a to b, one position per step, in play
  function automatic void push_run(int a, int b, int g0, int g, int s);
    int d;
    int gg;
    logic [15:0] one;
    d   = (b >= a) ? 1 : -1;
    gg  = g0;
    one = 16'h0001;
    for (int p = a; p != b + d; p += d) begin
      push(gg, 1'b0, one << p, p, 1'b1, s, 1'b1, 1'b0, 1'b0);
      gg = g;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1; rightplayer = 1'b0;
    step(); step();
    n_tot++;
    if (light !== 16'h0 || ball_pos !== 4'd0 || rightpscore !== 2'd0)
      $display("FAIL reset_regs: light=%h pos=%0d score=%0d want 0000 0 0", light, ball_pos, rightpscore);
    else n_pass++;
    n_tot++;
    if (gamestate !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0)
      $display("FAIL reset_flags: gs=%b hit=%b miss=%b want 0 0 0", gamestate, hit_pulse, miss_pulse);
    else n_pass++;
    reset = 1'b0;
    step();
    last_l = 16'h0;
  endtask

  task automatic test_serve();
    exp_t e;
    push(1, 1'b1, 16'h0001, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    push_run(1, 3, 8, 8, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL serve_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL serve_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  task automatic test_bounce_miss();
    exp_t e;
    push_run(4, 15, 8, 8, 0);
    push_run(14, 0, 8, 8, 0);
    push(8,  1'b0, 16'hFFFF, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    push(1,  1'b0, 16'hFFFF, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    push(7,  1'b0, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    push(8,  1'b0, 16'hFFFF, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    push(8,  1'b0, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    push(16, 1'b0, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL miss_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL miss_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  task automatic test_return_speedup();
    exp_t e;
    push(1, 1'b1, 16'h0001, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    push_run(1, 15, 8, 8, 0);
    push_run(14, 1, 8, 8, 0);
    push(1, 1'b1, 16'h0004, 2, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    push(1, 1'b0, 16'h0004, 2, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push_run(3, 15, 5, 6, 1);
    push_run(14, 0, 6, 6, 1);
    push(1, 1'b1, 16'h0002, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0);
    push(1, 1'b0, 16'h0002, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    push_run(2, 15, 3, 4, 2);
    push_run(14, 1, 4, 4, 2);
    push(1,  1'b1, 16'hFFFF, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0);
    push(1,  1'b0, 16'hFFFF, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    push(20, 1'b0, 16'hFFFF, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    push(1,  1'b1, 16'h0000, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    push(1,  1'b0, 16'h0000, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL return_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL return_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  task automatic test_window_held();
    exp_t e;
    push(1, 1'b1, 16'h0001, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    push_run(1, 15, 8, 8, 0);
    push_run(14, 1, 8, 8, 0);
    push(1, 1'b1, 16'h0004, 2, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    push(1, 1'b0, 16'h0004, 2, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push_run(3, 15, 5, 6, 1);
    push_run(14, 5, 6, 6, 1);
    push(1, 1'b1, 16'h0020, 5, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(1, 1'b0, 16'h0020, 5, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(4, 1'b0, 16'h0010, 4, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(6, 1'b1, 16'h0008, 3, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(6, 1'b1, 16'h0004, 2, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(6, 1'b1, 16'h0002, 1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(6, 1'b1, 16'h0001, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push(6,  1'b1, 16'hFFFF, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    push(1,  1'b0, 16'hFFFF, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    push(5,  1'b0, 16'h0000, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    push(6,  1'b0, 16'hFFFF, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    push(6,  1'b0, 16'h0000, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    push(12, 1'b0, 16'h0000, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL window_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL window_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  task automatic test_press_tick_same_cycle();
    exp_t e;
    push(1, 1'b1, 16'h0001, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    push_run(1, 15, 8, 8, 0);
    push_run(14, 0, 8, 8, 0);
    push(8, 1'b1, 16'h0002, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
    push(1, 1'b0, 16'h0002, 1, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    push_run(2, 9, 5, 6, 1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL same_cycle_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL same_cycle_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  task automatic test_reset_mid_rally();
    exp_t e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tot++;
    if (light !== 16'h0 || ball_pos !== 4'd0 || rightpscore !== 2'd0 || gamestate !== 1'b0)
      $display("FAIL mid_reset: light=%h pos=%0d score=%0d gs=%b want 0000 0 0 0",
               light, ball_pos, rightpscore, gamestate);
    else n_pass++;
    last_l = 16'h0;
    push(1, 1'b1, 16'h0001, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    push_run(1, 3, 8, 8, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.gap - 1) step();
      n_tot++;
      if (light !== last_l) $display("FAIL reserve_early: light=%h want %h", light, last_l);
      else n_pass++;
      rightplayer = e.btn; step();
      n_tot++;
      if (light !== e.l || rightpscore !== e.s || gamestate !== e.g || hit_pulse !== e.h ||
          miss_pulse !== e.m || (e.pv && ball_pos !== e.p))
        $display("FAIL reserve_step: light=%h pos=%0d score=%0d gs=%b hit=%b miss=%b want %h %0d %0d %b %b %b",
                 light, ball_pos, rightpscore, gamestate, hit_pulse, miss_pulse, e.l, e.p, e.s, e.g, e.h, e.m);
      else n_pass++;
      last_l = e.l;
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce_miss();
    test_return_speedup();
    test_window_held();
    test_press_tick_same_cycle();
    test_reset_mid_rally();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
